pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
- Parametrised, pipelined successor to the combinational unsigned adder tree.
- Sums LENGTH addends per beat through a balanced binary tree with a configurable register stride.
- Supports signed or unsigned operands, a valid/ready stream handshake with backpressure, and an optional running accumulation across beats with a sticky overflow flag.
- Sits between parallel datapath lanes (e.g. MAC/popcount arrays) and downstream stream consumers.

Parameters:
- DATA_WIDTH, 8, width of each addend.
- LENGTH, 42, number of addends per beat (>=1).
- SIGNED, 0, 0 = unsigned operands and sum; 1 = two's-complement with sign extension.
- LEVELS_PER_STAGE, 1, adder levels between pipeline registers (>=1).
- ACC_BITS, 8, extra headroom bits for accumulation.
- Derived: D = $clog2(LENGTH) (0 when LENGTH=1).
- Derived: SUM_WIDTH = DATA_WIDTH + D + ACC_BITS.
- Derived: LATENCY = ceil(D / LEVELS_PER_STAGE) + 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_addends  in  [DATA_WIDTH-1:0] x LENGTH (unpacked array)  operands.
- in_accumulate  in  1  1 = add this beat's sum to the previous output sum; 0 = start a fresh sum.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_sum  out  SUM_WIDTH  result; sign-extended when SIGNED=1.
- out_overflow  out  1  sticky overflow of the current accumulation chain.

Behaviour:
- Tree split:
  - Each node splits its n inputs into A = n/2 and B = n - A, the same split as the existing tree.
  - Node width = DATA_WIDTH + $clog2(n), extended per SIGNED.
  - The tree itself never overflows.
- Pipelining:
  - A register bank follows every LEVELS_PER_STAGE adder levels, counted from the leaves.
  - The final output register holds out_sum, out_overflow and out_valid.
  - Unbalanced leaves are delayed so that every path has equal latency.
  - in_accumulate travels with its beat.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0 the whole pipe holds and no stage changes.
  - When advance=1 all stages shift one position; bubbles (valid=0) shift too.
  - out_valid/out_sum stay stable while out_valid && !out_ready.
- Latency:
  - Input accepted at edge k appears with out_valid=1 after edge k+LATENCY-1, i.e. LATENCY cycles, provided no stall occurs.
  - With no stalls, throughput is one beat per cycle.
- Output stage (on an advance with a valid beat arriving, T = tree sum extended to SUM_WIDTH):
  - in_accumulate=0: out_sum = T; out_overflow = 0.
  - in_accumulate=1: out_sum = out_sum_prev + T, modulo 2^SUM_WIDTH; out_overflow = out_overflow_prev | ovf.
  - ovf, unsigned: carry out of SUM_WIDTH.
  - ovf, signed: operands share a sign and the result sign differs.
  - out_sum_prev is the last emitted sum; it is retained across bubbles.
  - in_accumulate=1 on the first beat after reset accumulates onto 0.
  - An advance with a bubble arriving clears out_valid and leaves out_sum/out_overflow unchanged.
- Reset:
  - All stage valids, out_valid, out_sum and out_overflow go to 0.
  - Beats in flight are discarded, including on a reset mid-stream or mid-stall.
  - in_ready = 1 in the cycle after reset.
- LENGTH=1:
  - No adders; LATENCY = 1.
  - T is the single addend, extended.

Test Plan:
- LENGTH=4, DATA_WIDTH=8, SIGNED=0, LPS=1, ACC_BITS=2 (LATENCY=3): addends {255,255,255,255}, in_accumulate=0, out_ready=1 -> out_valid 3 cycles later, out_sum=1020, out_overflow=0.
- Same config, SIGNED=1: addends {-128,-128,-128,-128} -> out_sum=-512 (12-bit 0xE00); addends {127,-1,0,1} -> 127.
- Same unsigned config, 5 back-to-back beats of all-255 with in_accumulate=0,1,1,1,1 -> out_sum sequence 1020, 2040, 3060, 4080, then 1004 with out_overflow=1; a next beat with in_accumulate=0 and addends {1,2,3,4} -> 10, out_overflow=0.
- Backpressure: stream beats with sums 1..6 while out_ready is held low for 4 cycles mid-stream -> in_ready low during the stall, out_sum held stable, all six sums emitted in order with none lost or duplicated.
- Reset mid-operation: assert rst for 1 cycle with 3 beats in flight -> no out_valid for those beats; a new beat with sum 7 appears LATENCY cycles after its acceptance.
- LENGTH=42 with LPS=2, and LENGTH=1: random addends checked against a reference sum with latency 4 and 1 respectively; includes bubbles interleaved with valid beats.

Source files
------------

// File: rtl/pipelined_adder_tree.sv
// Pipelined adder tree: sums LENGTH addends per beat behind a valid/ready stream, with a
// configurable register stride and optional running accumulation with a sticky overflow flag.
module pipelined_adder_tree #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned LENGTH           = 42,
  parameter int unsigned SIGNED           = 0,
  parameter int unsigned LEVELS_PER_STAGE = 1,
  parameter int unsigned ACC_BITS         = 8,
  localparam int unsigned D               = $clog2(LENGTH),
  localparam int unsigned SUM_WIDTH       = DATA_WIDTH + D + ACC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_addends [LENGTH],
  input  logic                  in_accumulate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SUM_WIDTH-1:0]  out_sum,
  output logic                  out_overflow
);

  // Tree nodes are carried at the root width; the true partial sums always fit, so no overflow.
  localparam int unsigned TW = DATA_WIDTH + D;

  function automatic int unsigned level_nodes(int unsigned lvl);
    return (LENGTH + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int unsigned L    = l;
    localparam int unsigned N    = level_nodes(L);
    localparam bit          Bank = (L > 0) && ((L % LEVELS_PER_STAGE == 0) || (L == D));

    logic [TW-1:0] val [N];
    logic          vld;
    logic          acc;

    if (L == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_ext
        if (SIGNED != 0) begin : g_sx
          assign val[i] = TW'($signed(in_addends[i]));
        end else begin : g_zx
          assign val[i] = TW'(in_addends[i]);
        end
      end
      assign vld = in_valid;
      assign acc = in_accumulate;
    end else begin : g_node
      localparam int unsigned NP = level_nodes(L - 1);
      logic [TW-1:0] sum [N];

      // Adjacent pairs reduce per level; an odd trailing node passes through unchanged, which
      // keeps every leaf-to-root path at the same register count.
      for (genvar i = 0; i < N; i++) begin : g_add
        if (2 * i + 1 < NP) begin : g_pair
          assign sum[i] = g_lvl[l-1].val[2*i] + g_lvl[l-1].val[2*i+1];
        end else begin : g_pass
          assign sum[i] = g_lvl[l-1].val[2*i];
        end
      end

      if (Bank) begin : g_reg
        logic [TW-1:0] val_q [N];
        logic          vld_q;
        logic          acc_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            vld_q <= 1'b0;
            acc_q <= 1'b0;
          end else if (advance) begin
            vld_q <= g_lvl[l-1].vld;
            acc_q <= g_lvl[l-1].acc;
          end
        end

        always_ff @(posedge clk) begin
          if (advance) begin
            val_q <= sum;
          end
        end

        assign val = val_q;
        assign vld = vld_q;
        assign acc = acc_q;
      end else begin : g_wire
        assign val = sum;
        assign vld = g_lvl[l-1].vld;
        assign acc = g_lvl[l-1].acc;
      end
    end
  end

  logic [SUM_WIDTH-1:0] tree_sum;
  logic [SUM_WIDTH:0]   acc_full;
  logic [SUM_WIDTH-1:0] acc_sum;
  logic                 ovf;

  if (SIGNED != 0) begin : g_root_sx
    assign tree_sum = SUM_WIDTH'($signed(g_lvl[D].val[0]));
  end else begin : g_root_zx
    assign tree_sum = SUM_WIDTH'(g_lvl[D].val[0]);
  end

  always_comb begin
    acc_full = {1'b0, out_sum} + {1'b0, tree_sum};
    acc_sum  = acc_full[SUM_WIDTH-1:0];
    if (SIGNED != 0) begin
      ovf = (out_sum[SUM_WIDTH-1] == tree_sum[SUM_WIDTH-1]) &&
            (acc_sum[SUM_WIDTH-1] != out_sum[SUM_WIDTH-1]);
    end else begin
      ovf = acc_full[SUM_WIDTH];
    end
  end

  // Bubbles clear out_valid but keep out_sum so a later accumulate continues the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else if (advance) begin
      out_valid <= g_lvl[D].vld;
      if (g_lvl[D].vld) begin
        if (g_lvl[D].acc) begin
          out_sum      <= acc_sum;
          out_overflow <= out_overflow | ovf;
        end else begin
          out_sum      <= tree_sum;
          out_overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: four configurations (4-lane unsigned/signed,
// 42-lane with two levels per stage, single lane) checked against hand-computed sums.
module tb_pipelined_adder_tree;

  localparam int LAT_W = 4;
  localparam int LAT_1 = 1;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int num_checks = 0;
  int num_errors = 0;
  exp_t q_u[$], q_s[$], q_w[$], q_1[$];

  logic       rst, u_rst;
  // 4-lane unsigned
  logic       u_in_valid, u_in_ready, u_acc, u_out_valid, u_out_ready, u_out_ovf;
  logic [7:0] u_addends [4];
  logic [11:0] u_out_sum;
  // 4-lane signed
  logic       s_in_valid, s_in_ready, s_acc, s_out_valid, s_out_ready, s_out_ovf;
  logic [7:0] s_addends [4];
  logic [11:0] s_out_sum;
  // 42-lane, two levels per stage
  logic       w_in_valid, w_in_ready, w_acc, w_out_valid, w_out_ready, w_out_ovf;
  logic [7:0] w_addends [42];
  logic [21:0] w_out_sum;
  // single lane
  logic       o_in_valid, o_in_ready, o_acc, o_out_valid, o_out_ready, o_out_ovf;
  logic [7:0] o_addends [1];
  logic [15:0] o_out_sum;

  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(4), .SIGNED(0), .LEVELS_PER_STAGE(1),
                         .ACC_BITS(2)) dut_u (
    .clk(clk), .rst(u_rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_addends(u_addends), .in_accumulate(u_acc), .out_valid(u_out_valid),
    .out_ready(u_out_ready), .out_sum(u_out_sum), .out_overflow(u_out_ovf)
  );

  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(4), .SIGNED(1), .LEVELS_PER_STAGE(1),
                         .ACC_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_addends(s_addends), .in_accumulate(s_acc), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_sum(s_out_sum), .out_overflow(s_out_ovf)
  );

  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(42), .SIGNED(0), .LEVELS_PER_STAGE(2),
                         .ACC_BITS(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_addends(w_addends), .in_accumulate(w_acc), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_sum(w_out_sum), .out_overflow(w_out_ovf)
  );

  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(1), .SIGNED(0), .LEVELS_PER_STAGE(1),
                         .ACC_BITS(8)) dut_o (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_addends(o_addends), .in_accumulate(o_acc), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_sum(o_out_sum), .out_overflow(o_out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic o, input int c);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    e.cyc = c;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one 4-lane beat, wait (bounded) for acceptance, optionally queue its expected result.
  task automatic send4(input bit sel, input logic [7:0] a0, a1, a2, a3, input logic acc,
                       input bit push, input logic [11:0] es, input logic eo);
    int n;
    n = 0;
    if (sel) begin
      s_addends = '{a0, a1, a2, a3}; s_acc = acc; s_in_valid = 1'b1;
    end else begin
      u_addends = '{a0, a1, a2, a3}; u_acc = acc; u_in_valid = 1'b1;
    end
    #1;
    while (!(sel ? s_in_ready : u_in_ready) && n < 50) begin
      step();
      #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    if (push) begin
      if (sel) q_s.push_back(mk(32'(es), eo, -1));
      else q_u.push_back(mk(32'(es), eo, -1));
    end
    step();
    if (sel) s_in_valid = 1'b0;
    else u_in_valid = 1'b0;
  endtask

  // Output monitors: a transfer happens at the next rising edge when valid && ready here.
  logic        u_prev_stall = 1'b0;
  logic [11:0] u_prev_sum = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!u_rst && u_out_valid && !u_out_ready) begin
      if (u_prev_stall) check("u_hold_sum", 32'(u_out_sum), 32'(u_prev_sum));
      check("u_stall_ready", 32'(u_in_ready), 32'd0);
      u_prev_stall = 1'b1;
      u_prev_sum   = u_out_sum;
    end else begin
      u_prev_stall = 1'b0;
    end
    if (!u_rst && u_out_valid && u_out_ready) begin
      if (q_u.size() == 0) begin
        check("u_unexpected_valid", 32'(u_out_valid), 32'd0);
      end else begin
        e = q_u.pop_front();
        check("u_sum", 32'(u_out_sum), e.sum);
        check("u_ovf", 32'(u_out_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && s_out_valid && s_out_ready) begin
      if (q_s.size() == 0) begin
        check("s_unexpected_valid", 32'(s_out_valid), 32'd0);
      end else begin
        e = q_s.pop_front();
        check("s_sum", 32'(s_out_sum), e.sum);
        check("s_ovf", 32'(s_out_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && w_out_valid && w_out_ready) begin
      if (q_w.size() == 0) begin
        check("w_unexpected_valid", 32'(w_out_valid), 32'd0);
      end else begin
        e = q_w.pop_front();
        check("w_sum", 32'(w_out_sum), e.sum);
        check("w_ovf", 32'(w_out_ovf), 32'(e.ovf));
        check("w_latency", 32'(cyc - e.cyc), 32'(LAT_W - 1));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_out_valid && o_out_ready) begin
      if (q_1.size() == 0) begin
        check("o_unexpected_valid", 32'(o_out_valid), 32'd0);
      end else begin
        e = q_1.pop_front();
        check("o_sum", 32'(o_out_sum), e.sum);
        check("o_ovf", 32'(o_out_ovf), 32'(e.ovf));
        check("o_latency", 32'(cyc - e.cyc), 32'(LAT_1 - 1));
      end
    end
  end

  logic [31:0] prev_w, prev_o, t_w, t_o, es;

  initial begin
    rst = 1'b1; u_rst = 1'b1;
    u_in_valid = 1'b0; u_acc = 1'b0; u_out_ready = 1'b1; u_addends = '{8'd0, 8'd0, 8'd0, 8'd0};
    s_in_valid = 1'b0; s_acc = 1'b0; s_out_ready = 1'b1; s_addends = '{8'd0, 8'd0, 8'd0, 8'd0};
    w_in_valid = 1'b0; w_acc = 1'b0; w_out_ready = 1'b1;
    for (int i = 0; i < 42; i++) w_addends[i] = 8'd0;
    o_in_valid = 1'b0; o_acc = 1'b0; o_out_ready = 1'b1; o_addends[0] = 8'd0;
    prev_w = '0; prev_o = '0;
    step();
    step();
    rst = 1'b0; u_rst = 1'b0;

    // Reset state
    check("rst_u_valid", 32'(u_out_valid), 32'd0);
    check("rst_u_sum", 32'(u_out_sum), 32'd0);
    check("rst_u_ovf", 32'(u_out_ovf), 32'd0);
    check("rst_u_ready", 32'(u_in_ready), 32'd1);
    check("rst_w_valid", 32'(w_out_valid), 32'd0);
    check("rst_o_valid", 32'(o_out_valid), 32'd0);

    // Single all-255 beat, latency 3
    u_addends = '{8'd255, 8'd255, 8'd255, 8'd255}; u_acc = 1'b0; u_in_valid = 1'b1;
    q_u.push_back(mk(32'd1020, 1'b0, -1));
    step();
    u_in_valid = 1'b0;
    check("lat_edge0", 32'(u_out_valid), 32'd0);
    step();
    check("lat_edge1", 32'(u_out_valid), 32'd0);
    step();
    check("lat_edge2", 32'(u_out_valid), 32'd1);
    check("lat_sum", 32'(u_out_sum), 32'd1020);
    step();

    // Accumulation chain wrapping past 12 bits, then a fresh sum
    send4(1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 12'd1020, 1'b0);
    send4(1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 12'd2040, 1'b0);
    send4(1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 12'd3060, 1'b0);
    send4(1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 12'd4080, 1'b0);
    send4(1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 12'd1004, 1'b1);
    send4(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b1, 12'd10, 1'b0);

    // Signed: -512, accumulate down to -2048, one more wraps with overflow, then 127
    send4(1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 12'hE00, 1'b0);
    send4(1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 12'hC00, 1'b0);
    send4(1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 12'hA00, 1'b0);
    send4(1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 12'h800, 1'b0);
    send4(1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 12'h600, 1'b1);
    send4(1'b1, 8'h7F, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b1, 12'h07F, 1'b0);
    repeat (4) step();

    // Backpressure: six beats while out_ready drops for four cycles
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send4(1'b0, 8'(k), 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 12'(k), 1'b0);
        end
      end
      begin
        step();
        step();
        u_out_ready = 1'b0;
        repeat (4) step();
        u_out_ready = 1'b1;
      end
    join
    repeat (5) step();
    check("bp_drained", 32'(q_u.size()), 32'd0);

    // Reset with beats in flight: none may emerge
    u_addends = '{8'd5, 8'd0, 8'd0, 8'd0}; u_acc = 1'b0; u_in_valid = 1'b1;
    step();
    step();
    u_rst = 1'b1;
    step();
    u_rst = 1'b0; u_in_valid = 1'b0;
    check("midrst_valid", 32'(u_out_valid), 32'd0);
    check("midrst_sum", 32'(u_out_sum), 32'd0);
    check("midrst_ready", 32'(u_in_ready), 32'd1);
    step();
    check("midrst_valid_1", 32'(u_out_valid), 32'd0);
    step();
    check("midrst_valid_2", 32'(u_out_valid), 32'd0);
    // Accumulate right after reset starts from 0
    u_addends = '{8'd3, 8'd4, 8'd0, 8'd0}; u_acc = 1'b1; u_in_valid = 1'b1;
    q_u.push_back(mk(32'd7, 1'b0, -1));
    step();
    u_in_valid = 1'b0;
    check("post_rst_edge0", 32'(u_out_valid), 32'd0);
    step();
    check("post_rst_edge1", 32'(u_out_valid), 32'd0);
    step();
    check("post_rst_edge2", 32'(u_out_valid), 32'd1);
    check("post_rst_sum", 32'(u_out_sum), 32'd7);
    step();

    // 42-lane and single-lane streams with bubbles and occasional accumulation
    for (int it = 0; it < 60; it++) begin
      w_in_valid = ($urandom_range(0, 9) < 7);
      w_acc      = ($urandom_range(0, 3) == 0);
      t_w = '0;
      for (int i = 0; i < 42; i++) begin
        w_addends[i] = 8'($urandom_range(0, 255));
        t_w = t_w + 32'(w_addends[i]);
      end
      o_in_valid   = ($urandom_range(0, 9) < 7);
      o_acc        = ($urandom_range(0, 3) == 0);
      o_addends[0] = 8'($urandom_range(0, 255));
      t_o = 32'(o_addends[0]);
      #1;
      check("w_ready", 32'(w_in_ready), 32'd1);
      if (w_in_valid) begin
        es = w_acc ? ((prev_w + t_w) & 32'h3F_FFFF) : t_w;
        prev_w = es;
        q_w.push_back(mk(es, 1'b0, cyc + 1));
      end
      if (o_in_valid) begin
        es = o_acc ? ((prev_o + t_o) & 32'h0000_FFFF) : t_o;
        prev_o = es;
        q_1.push_back(mk(es, 1'b0, cyc + 1));
      end
      step();
    end
    w_in_valid = 1'b0;
    o_in_valid = 1'b0;
    repeat (8) step();

    check("u_drained", 32'(q_u.size()), 32'd0);
    check("s_drained", 32'(q_s.size()), 32'd0);
    check("w_drained", 32'(q_w.size()), 32'd0);
    check("o_drained", 32'(q_1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
